// File: rtl/bus_xfer_pkg.sv
// Shared constants and state encoding for the bus transfer sequencer.
package bus_xfer_pkg;

    // Number of bus registers driven; fixed at 4 in this revision.
    localparam int unsigned NREG  = 4;
    // Width of a register select field.
    localparam int unsigned SEL_W = $clog2(NREG);

    // Transfer sequencer states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        LATCH = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/onehot_dec.sv
// Binary-to-one-hot decoder with enable; output is all zeros when disabled.
module onehot_dec #(
    parameter int unsigned SEL_W = 2,
    parameter int unsigned NREG  = 4
) (
    input  logic [SEL_W-1:0] sel,
    input  logic             en,
    output logic [NREG-1:0]  hot
);

    // Set exactly one bit when enabled, none otherwise.
    always_comb begin
        hot = '0;
        if (en) begin
            hot[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/bus_xfer_seq.sv
// Register-to-register bus transfer sequencer. A request in IDLE drives the
// source register onto the bus (DRIVE), then strobes the destination load
// (LATCH), then reports completion (DONE). All outputs are registered.
module bus_xfer_seq
    import bus_xfer_pkg::*;
#(
    parameter int unsigned NREG  = bus_xfer_pkg::NREG,
    parameter int unsigned SEL_W = bus_xfer_pkg::SEL_W
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [SEL_W-1:0] src,
    input  logic [SEL_W-1:0] dst,
    output logic [NREG-1:0]  oen,
    output logic [NREG-1:0]  inen,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [7:0]       xfer_cnt
);

    if (SEL_W != $clog2(NREG)) begin : g_bad_sel_w
        $error("SEL_W must equal clog2(NREG)");
    end

    state_e           state;
    logic [SEL_W-1:0] src_q;
    logic [SEL_W-1:0] dst_q;
    logic             accept;
    logic             reject;
    logic [SEL_W-1:0] src_sel;
    logic [NREG-1:0]  src_hot;
    logic [NREG-1:0]  dst_hot;

    // Requests are only looked at in IDLE; same-register transfers are refused.
    assign accept = (state == IDLE) && start && (src != dst);
    assign reject = (state == IDLE) && start && (src == dst);

    // At acceptance the live src is decoded; during DRIVE the latched copy is
    // re-decoded so oen can never follow a mid-transfer change of src.
    assign src_sel = (state == IDLE) ? src : src_q;

    onehot_dec #(
        .SEL_W (SEL_W),
        .NREG  (NREG)
    ) u_oen_dec (
        .sel (src_sel),
        .en  (accept || (state == DRIVE)),
        .hot (src_hot)
    );

    onehot_dec #(
        .SEL_W (SEL_W),
        .NREG  (NREG)
    ) u_inen_dec (
        .sel (dst_q),
        .en  (state == DRIVE),
        .hot (dst_hot)
    );

    // Sequencer state, latched selects, registered strobes/flags and counter.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state    <= IDLE;
            src_q    <= '0;
            dst_q    <= '0;
            oen      <= '0;
            inen     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            xfer_cnt <= 8'd0;
        end else begin
            // Pulses default low; each lasts exactly one cycle.
            done <= 1'b0;
            err  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        state <= DRIVE;
                        src_q <= src;
                        dst_q <= dst;
                        oen   <= src_hot;
                        inen  <= '0;
                        busy  <= 1'b1;
                    end else if (reject) begin
                        err <= 1'b1;
                    end
                end
                DRIVE: begin
                    // Source keeps driving while the destination load is strobed.
                    state <= LATCH;
                    oen   <= src_hot;
                    inen  <= dst_hot;
                end
                LATCH: begin
                    // Destination captures on this edge; release the bus.
                    state    <= DONE;
                    oen      <= '0;
                    inen     <= '0;
                    done     <= 1'b1;
                    xfer_cnt <= xfer_cnt + 8'd1;
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    oen   <= '0;
                    inen  <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_xfer_seq.sv
// Scoreboard bench for bus_xfer_seq: stimulus pushes expected completions,
// a negedge monitor pops and compares on every done/err pulse.
module tb_bus_xfer_seq;

    logic       clk   = 1'b0;
    logic       clr   = 1'b0;
    logic       start = 1'b0;
    logic [1:0] src   = 2'd0;
    logic [1:0] dst   = 2'd0;
    logic [3:0] oen;
    logic [3:0] inen;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] xfer_cnt;

    always #5 clk = ~clk;

    bus_xfer_seq #(
        .NREG  (4),
        .SEL_W (2)
    ) dut (
        .clk      (clk),
        .clr      (clr),
        .start    (start),
        .src      (src),
        .dst      (dst),
        .oen      (oen),
        .inen     (inen),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .xfer_cnt (xfer_cnt)
    );

    typedef struct packed {
        logic       is_err;
        logic [3:0] oen;
        logic [3:0] inen;
        logic [7:0] cnt;
    } exp_t;

    exp_t       exp_q[$];
    int         checks  = 0;
    int         errors  = 0;
    logic [7:0] exp_cnt = 8'd0;

    // Four 8-bit registers sharing one bus, loaded on their inen strobe.
    logic [7:0] regs[4];
    logic [7:0] bus;
    logic       preset = 1'b0;

    always_comb begin
        bus = 8'h00;
        for (int k = 0; k < 4; k++) begin
            if (oen[k]) bus = bus | regs[k];
        end
    end

    always @(posedge clk) begin
        if (preset) begin
            regs[0] <= 8'hA5;
            regs[1] <= 8'h00;
            regs[2] <= 8'h00;
            regs[3] <= 8'h3C;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (inen[k]) regs[k] <= bus;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic push_valid(input logic [1:0] s, input logic [1:0] d);
        exp_t e;
        exp_cnt    = exp_cnt + 8'd1;
        e.is_err   = 1'b0;
        e.oen      = 4'b0001 << s;
        e.inen     = 4'b0001 << d;
        e.cnt      = exp_cnt;
        exp_q.push_back(e);
    endtask

    task automatic push_err();
        exp_t e;
        e.is_err = 1'b1;
        e.oen    = 4'b0000;
        e.inen   = 4'b0000;
        e.cnt    = exp_cnt;
        exp_q.push_back(e);
    endtask

    // One request held for one cycle; returns in the DONE cycle (or 3 cycles on).
    task automatic do_xfer(input logic [1:0] s, input logic [1:0] d);
        @(negedge clk);
        start = 1'b1;
        src   = s;
        dst   = d;
        if (s == d) push_err();
        else        push_valid(s, d);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // Monitor: accumulate strobes per transfer, compare at each completion.
    logic [3:0] seen_oen  = 4'b0;
    logic [3:0] seen_inen = 4'b0;

    initial begin : monitor
        exp_t e;
        logic ok;
        forever begin
            @(negedge clk);
            ok = $onehot0(oen) && $onehot0(inen) && !((inen != 4'b0) && (oen == 4'b0))
                 && ((oen & inen) == 4'b0);
            chk("strobe_invariants", 32'(ok), 32'd1);
            if (!clr) begin
                seen_oen  = 4'b0;
                seen_inen = 4'b0;
            end else begin
                seen_oen  = seen_oen | oen;
                seen_inen = seen_inen | inen;
                if (done || err) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_event", 32'({done, err}), 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("event_is_err", 32'(err), 32'(e.is_err));
                        chk("event_is_done", 32'(done), 32'(!e.is_err));
                        chk("xfer_oen", 32'(seen_oen), 32'(e.oen));
                        chk("xfer_inen", 32'(seen_inen), 32'(e.inen));
                        chk("xfer_cnt", 32'(xfer_cnt), 32'(e.cnt));
                    end
                    seen_oen  = 4'b0;
                    seen_inen = 4'b0;
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        // Reset state, observed with no clock edge required.
        #1;
        chk("rst_oen", 32'(oen), 32'h0);
        chk("rst_inen", 32'(inen), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done_err", 32'({done, err}), 32'h0);
        chk("rst_cnt", 32'(xfer_cnt), 32'h0);
        @(posedge clk);
        #2 clr = 1'b1;

        // Transfer 1 -> 3 with cycle-exact strobe checks.
        @(negedge clk);
        start = 1'b1;
        src   = 2'd1;
        dst   = 2'd3;
        push_valid(2'd1, 2'd3);
        @(negedge clk);
        start = 1'b0;
        chk("c1_oen", 32'(oen), 32'b0010);
        chk("c1_inen", 32'(inen), 32'b0000);
        chk("c1_busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk("c2_oen", 32'(oen), 32'b0010);
        chk("c2_inen", 32'(inen), 32'b1000);
        @(negedge clk);
        chk("c3_done", 32'(done), 32'd1);
        chk("c3_strobes", 32'({oen, inen}), 32'h0);
        chk("c3_cnt", 32'(xfer_cnt), 32'd1);
        @(negedge clk);
        chk("c4_idle", 32'({busy, done}), 32'h0);

        // Rejected request src == dst.
        @(negedge clk);
        start = 1'b1;
        src   = 2'd2;
        dst   = 2'd2;
        push_err();
        @(negedge clk);
        start = 1'b0;
        chk("rej_err", 32'(err), 32'd1);
        chk("rej_busy", 32'(busy), 32'd0);
        chk("rej_strobes", 32'({oen, inen}), 32'h0);
        @(negedge clk);
        chk("rej_err_pulse", 32'(err), 32'd0);
        chk("rej_cnt", 32'(xfer_cnt), 32'd1);

        // start held high, src/dst toggled mid-transfer.
        @(negedge clk);
        start = 1'b1;
        src   = 2'd0;
        dst   = 2'd1;
        push_valid(2'd0, 2'd1);
        @(negedge clk);
        src = 2'd3;
        dst = 2'd2;
        chk("hold_drive_oen", 32'(oen), 32'b0001);
        @(negedge clk);
        src = 2'd2;
        dst = 2'd0;
        chk("hold_latch_strobes", 32'({oen, inen}), 32'h12);
        @(negedge clk);
        src = 2'd3;
        dst = 2'd0;
        chk("hold_done", 32'(done), 32'd1);
        push_valid(2'd3, 2'd0);
        @(negedge clk);
        chk("hold_back_idle", 32'({busy, oen}), 32'h0);
        @(negedge clk);
        start = 1'b0;
        chk("hold_second_oen", 32'({busy, oen}), 32'h18);
        repeat (2) @(negedge clk);

        // Abort by clr during LATCH.
        @(negedge clk);
        start = 1'b1;
        src   = 2'd0;
        dst   = 2'd1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("abort_latch_inen", 32'(inen), 32'b0010);
        #1 clr = 1'b0;
        #1;
        chk("abort_strobes", 32'({oen, inen}), 32'h0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_cnt", 32'(xfer_cnt), 32'd0);
        exp_cnt = 8'd0;
        @(posedge clk);
        #1 chk("abort_no_done", 32'(done), 32'd0);
        @(posedge clk);
        #2 clr = 1'b1;
        do_xfer(2'd3, 2'd2);

        // Shared-bus integration: register 0 preset to A5, moved to register 2.
        @(negedge clk);
        preset = 1'b1;
        @(negedge clk);
        preset = 1'b0;
        do_xfer(2'd0, 2'd2);
        @(negedge clk);
        chk("bus_reg2", 32'(regs[2]), 32'hA5);
        chk("bus_reg0", 32'(regs[0]), 32'hA5);
        chk("bus_reg3", 32'(regs[3]), 32'h3C);

        // Counter wrap: 256 transfers from a freshly cleared count.
        repeat (2) @(negedge clk);
        #1 clr = 1'b0;
        exp_cnt = 8'd0;
        @(posedge clk);
        @(posedge clk);
        #2 clr = 1'b1;
        for (int i = 0; i < 256; i++) begin
            do_xfer(2'(i % 4), 2'((i + 1) % 4));
        end
        @(negedge clk);
        chk("cnt_wrap", 32'(xfer_cnt), 32'd0);

        repeat (4) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
